// File: rtl/uart_bus_arbiter.sv
// Two-master round-robin arbiter driving a single-beat AHB-lite transfer to the UART bridge.
// Latency: grant N, address phase N+1, done at N+3 plus slave wait cycles; slave stalls via HREADY_i, bounded by TIMEOUT.
module uart_bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_write_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_done_o,
  output logic        m0_err_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_write_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_done_o,
  output logic        m1_err_o,
  output logic [31:0] m1_rdata_o,
  output logic        HSEL_o,
  output logic [1:0]  HTRANS_o,
  output logic        HWRITE_o,
  output logic [31:0] HADDR_o,
  output logic [31:0] HWDATA_o,
  output logic [2:0]  HSIZE_o,
  input  logic        HREADY_i,
  input  logic [1:0]  HRESP_i,
  input  logic [31:0] HRDATA_i,
  output logic        busy_o,
  output logic        owner_o
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        owner_q;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [7:0]  wait_q;
  logic        grant_vld;
  logic        grant_m1;
  logic        timeout_hit;

  assign timeout_hit = (wait_q == WAIT_LAST);

  always_comb begin
    state_d   = state_q;
    grant_vld = 1'b0;
    grant_m1  = 1'b0;
    HSEL_o    = 1'b0;
    HTRANS_o  = 2'b00;
    busy_o    = 1'b1;
    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (m0_req_i || m1_req_i) begin
          grant_vld = 1'b1;
          // On contention the master that did not win last time goes first.
          grant_m1  = (m0_req_i && m1_req_i) ? ~owner_q : m1_req_i;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        HSEL_o   = 1'b1;
        HTRANS_o = 2'b10;
        state_d  = DATA;
      end
      DATA: begin
        if (HREADY_i || timeout_hit) state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign m0_gnt_o = grant_vld && !grant_m1 && !rst_i;
  assign m1_gnt_o = grant_vld &&  grant_m1 && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b1;
      write_q <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      wait_q  <= 8'h0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            owner_q <= grant_m1;
            write_q <= grant_m1 ? m1_write_i : m0_write_i;
            addr_q  <= grant_m1 ? m1_addr_i  : m0_addr_i;
            wdata_q <= grant_m1 ? m1_wdata_i : m0_wdata_i;
          end
        end
        ADDR: wait_q <= 8'h0;
        DATA: begin
          if (HREADY_i) begin
            rdata_q <= HRDATA_i;
            err_q   <= |HRESP_i;
          end else begin
            wait_q <= wait_q + 8'h1;
            if (timeout_hit) begin
              rdata_q <= 32'h0;
              err_q   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign HWRITE_o   = write_q;
  assign HADDR_o    = addr_q;
  assign HWDATA_o   = wdata_q;
  assign HSIZE_o    = 3'b000;
  assign owner_o    = owner_q;

  // Completion is only ever visible on the owning master's side.
  assign m0_done_o  = (state_q == RESP) && !owner_q;
  assign m1_done_o  = (state_q == RESP) &&  owner_q;
  assign m0_err_o   = m0_done_o && err_q;
  assign m1_err_o   = m1_done_o && err_q;
  assign m0_rdata_o = m0_done_o ? rdata_q : 32'h0;
  assign m1_rdata_o = m1_done_o ? rdata_q : 32'h0;

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Randomized scoreboard bench for uart_bus_arbiter: a transaction-level model predicts grants and
// completions, a slave model answers the bus, and a negedge monitor compares everything it sees.
module tb_uart_bus_arbiter;

  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_req_i, m0_write_i, m1_req_i, m1_write_i;
  logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
  logic        m0_gnt_o, m0_done_o, m0_err_o, m1_gnt_o, m1_done_o, m1_err_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        HSEL_o, HWRITE_o, HREADY_i, busy_o, owner_o;
  logic [1:0]  HTRANS_o, HRESP_i;
  logic [31:0] HADDR_o, HWDATA_o, HRDATA_i;
  logic [2:0]  HSIZE_o;

  uart_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_gnt_o(m0_gnt_o), .m0_done_o(m0_done_o), .m0_err_o(m0_err_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_gnt_o(m1_gnt_o), .m1_done_o(m1_done_o), .m1_err_o(m1_err_o), .m1_rdata_o(m1_rdata_o),
    .HSEL_o(HSEL_o), .HTRANS_o(HTRANS_o), .HWRITE_o(HWRITE_o), .HADDR_o(HADDR_o),
    .HWDATA_o(HWDATA_o), .HSIZE_o(HSIZE_o), .HREADY_i(HREADY_i), .HRESP_i(HRESP_i),
    .HRDATA_i(HRDATA_i), .busy_o(busy_o), .owner_o(owner_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { bit m; logic [31:0] addr; bit write; logic [31:0] wdata; bit b2b; } gexp_t;
  typedef struct { bit m; bit err; logic [31:0] rdata; int lat; } dexp_t;
  typedef struct { int w; logic [1:0] resp; logic [31:0] rdata; } plan_t;

  gexp_t gq[$];
  dexp_t dq[$];
  plan_t pq[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit last_m   = 1'b1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level prediction: who wins, what reaches the bus, and how the transfer ends.
  task automatic issue(bit r0, bit r1, bit b2b, logic [31:0] a0, logic [31:0] d0, bit wr0,
                       logic [31:0] a1, logic [31:0] d1, bit wr1, int w, logic [1:0] resp,
                       logic [31:0] rd);
    bit win;
    bit tmo;
    int k;
    m0_req_i = r0; m0_addr_i = a0; m0_wdata_i = d0; m0_write_i = wr0;
    m1_req_i = r1; m1_addr_i = a1; m1_wdata_i = d1; m1_write_i = wr1;
    win    = (r0 && r1) ? !last_m : r1;
    last_m = win;
    tmo    = (w >= TO);
    gq.push_back('{win, win ? a1 : a0, win ? wr1 : wr0, win ? d1 : d0, b2b});
    pq.push_back('{w, resp, rd});
    dq.push_back('{win, tmo ? 1'b1 : (resp != 2'b00), tmo ? 32'h0 : rd, tmo ? TO + 2 : w + 3});
    for (k = 0; k < 200; k++) begin
      @(negedge clk_i);
      if (m0_gnt_o || m1_gnt_o) break;
    end
    if (k == 200) begin
      n_checks++; n_fail++;
      $display("FAIL gnt_wait: got no grant expected one within 200 cycles");
    end
    @(posedge clk_i); #1;
  endtask

  task automatic issue_rand(bit b2b);
    int p;
    int w;
    logic [1:0] resp;
    p    = $urandom_range(0, 2);
    w    = ($urandom_range(0, 9) > 7) ? TO + $urandom_range(0, 2) : $urandom_range(0, 3);
    resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    issue(p != 1, p != 0, b2b, $urandom, $urandom, 1'($urandom), $urandom, $urandom,
          1'($urandom), w, resp, $urandom);
  endtask

  task automatic idle_gap();
    int k;
    m0_req_i = 1'b0; m1_req_i = 1'b0;
    for (k = 0; k < 50; k++) begin
      @(negedge clk_i);
      if (!busy_o) break;
    end
    if (k == 50) begin
      n_checks++; n_fail++;
      $display("FAIL idle_wait: got busy expected idle within 50 cycles");
    end
    repeat ($urandom_range(0, 2)) @(negedge clk_i);
    @(posedge clk_i); #1;
  endtask

  // Slave model: answers the address phase it sees with the next queued plan.
  initial begin
    plan_t cur;
    int c;
    bit act;
    act = 1'b0; c = 0; cur = '{0, 2'b00, 32'h0};
    HREADY_i = 1'b1; HRESP_i = 2'b00; HRDATA_i = 32'h0;
    forever begin
      @(negedge clk_i);
      if (rst_i) act = 1'b0;
      else if (HSEL_o && HTRANS_o == 2'b10) begin
        act = 1'b1; c = 0;
        if (pq.size() > 0) cur = pq.pop_front();
        else cur = '{0, 2'b00, 32'h0};
      end
      if (!rst_i && act && busy_o && !HSEL_o && !m0_done_o && !m1_done_o) begin
        HREADY_i = (c == cur.w);
        HRESP_i  = (c == cur.w) ? cur.resp  : 2'($urandom);
        HRDATA_i = (c == cur.w) ? cur.rdata : $urandom;
        c++;
        if (c > cur.w) act = 1'b0;
      end else begin
        HREADY_i = 1'($urandom); HRESP_i = 2'($urandom); HRDATA_i = $urandom;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT grants, drives the bus or completes.
  int    cyc = 0;
  int    gnt_cyc = -100;
  int    last_done_cyc = -100;
  gexp_t cur_g = '{0, 32'h0, 0, 32'h0, 0};
  initial begin
    dexp_t d;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!rst_i) begin
        if (m0_gnt_o || m1_gnt_o) begin
          chk("gnt_onehot", {m0_gnt_o, m1_gnt_o} == 2'b11, 0);
          chk("gnt_in_idle", busy_o, 0);
          if (gq.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_gnt: got grant m1=%0d expected none", m1_gnt_o);
          end else begin
            cur_g = gq.pop_front();
            chk("gnt_who", m1_gnt_o, cur_g.m);
            if (cur_g.b2b) chk("gnt_after_done", cyc - last_done_cyc, 1);
            gnt_cyc = cyc;
          end
        end
        if (HTRANS_o == 2'b10) begin
          chk("addr_cycle", cyc - gnt_cyc, 1);
          chk("addr_haddr", HADDR_o, cur_g.addr);
          chk("addr_hwrite", HWRITE_o, cur_g.write);
          chk("addr_hsel", HSEL_o, 1);
          chk("addr_owner", owner_o, cur_g.m);
          chk("addr_busy", busy_o, 1);
        end
        if (cyc == gnt_cyc + 2) begin
          chk("data_hwdata", HWDATA_o, cur_g.wdata);
          chk("data_htrans_hsel", {HSEL_o, HTRANS_o}, 0);
        end
        if (m0_done_o || m1_done_o) begin
          chk("done_onehot", {m0_done_o, m1_done_o} == 2'b11, 0);
          if (dq.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_done: got done m1=%0d expected none", m1_done_o);
          end else begin
            d = dq.pop_front();
            chk("done_who", m1_done_o, d.m);
            chk("done_err", d.m ? m1_err_o : m0_err_o, d.err);
            chk("done_rdata", d.m ? m1_rdata_o : m0_rdata_o, d.rdata);
            chk("done_latency", cyc - gnt_cyc, d.lat);
            chk("done_other_side", d.m ? {m0_err_o, m0_rdata_o[30:0]} : {m1_err_o, m1_rdata_o[30:0]}, 0);
            chk("done_busy", busy_o, 1);
          end
          last_done_cyc = cyc;
        end
      end
    end
  end

  initial begin
    int k;
    rst_i = 1'b1;
    m0_req_i = 0; m0_write_i = 0; m0_addr_i = 0; m0_wdata_i = 0;
    m1_req_i = 0; m1_write_i = 0; m1_addr_i = 0; m1_wdata_i = 0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_busy", busy_o, 0);
    chk("rst_bus", {HSEL_o, HTRANS_o, HWRITE_o, HSIZE_o}, 0);
    chk("rst_haddr", HADDR_o, 0);
    chk("rst_hwdata", HWDATA_o, 0);
    chk("rst_flags", {m0_gnt_o, m1_gnt_o, m0_done_o, m1_done_o, m0_err_o, m1_err_o}, 0);
    chk("rst_rdata", m0_rdata_o | m1_rdata_o, 0);
    chk("rst_owner", owner_o, 1);
    @(posedge clk_i); #1;

    issue(1, 0, 0, 32'h10, 32'hA5, 1, $urandom, $urandom, 0, 0, 2'b00, $urandom);
    issue(0, 1, 1, $urandom, $urandom, 1, 32'h44, $urandom, 0, 3, 2'b00, 32'h55);
    repeat (4) issue(1, 1, 1, $urandom, $urandom, 1'($urandom), $urandom, $urandom, 1'($urandom), 0, 2'b00, $urandom);
    issue(1, 0, 1, 32'h20, $urandom, 0, $urandom, $urandom, 0, TO + 2, 2'b00, 32'hDEAD);
    issue(0, 1, 1, $urandom, $urandom, 0, 32'h30, $urandom, 0, 0, 2'b01, 32'h11);
    issue(1, 0, 1, 32'h34, $urandom, 0, $urandom, $urandom, 0, 1, 2'b10, 32'h22);
    issue(0, 1, 1, $urandom, $urandom, 0, 32'h38, $urandom, 1, 2, 2'b11, 32'h33);
    idle_gap();
    issue(1, 0, 0, $urandom, $urandom, 0, $urandom, $urandom, 0, TO - 1, 2'b00, 32'h77);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle_gap();
        issue_rand(0);
      end else issue_rand(1);
    end

    // Abort a transfer mid data phase; it must vanish without a completion.
    idle_gap();
    issue(0, 1, 0, $urandom, $urandom, 0, 32'h50, $urandom, 0, 5, 2'b00, 32'h99);
    m0_req_i = 0; m1_req_i = 0;
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
    gq.delete(); dq.delete(); pq.delete();
    last_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("abort_busy", busy_o, 0);
      chk("abort_htrans", HTRANS_o, 0);
      chk("abort_done", {m0_done_o, m1_done_o}, 0);
    end
    @(posedge clk_i); #1;
    issue(1, 1, 0, 32'h60, $urandom, 1, 32'h64, $urandom, 1, 0, 2'b00, $urandom);
    m0_req_i = 0; m1_req_i = 0;

    for (k = 0; k < 200; k++) begin
      @(negedge clk_i);
      if (dq.size() == 0 && !busy_o) break;
    end
    if (k == 200) begin
      n_checks++; n_fail++;
      $display("FAIL drain: got %0d pending completions expected 0", dq.size());
    end
    repeat (2) @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
